// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the alu_seq block.
// ALU_SEQ_DIV_EN selects whether the DIV state exists.
package alu_pkg;

    localparam logic [4:0] OP_PASS = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_CMPU = 5'b00101;
    localparam logic [4:0] OP_CMPS = 5'b11110;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_XNOR = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_MOD  = 5'b01110;
    localparam logic [4:0] OP_LSR  = 5'b11000;
    localparam logic [4:0] OP_LSL  = 5'b11001;
    localparam logic [4:0] OP_ASR  = 5'b11010;
    localparam logic [4:0] OP_ROR  = 5'b11100;

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd2
    } alu_state_t;
`endif

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic cout;
        logic div_invalid;
    } alu_flags_t;

    function automatic logic is_divmod(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module alu_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             running_q, running_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // The quotient register doubles as the dividend shifter.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvsr_q};

    always_comb begin
        running_d = running_q;
        count_d   = count_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        if (start) begin
            running_d = 1'b1;
            count_d   = CW'(WIDTH);
            quot_d    = dividend;
            rem_d     = '0;
            dvsr_d    = divisor;
        end else if (running_q) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            count_q   <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
        end else begin
            running_q <= running_d;
            count_q   <= count_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
        end
    end

    assign done      = running_q && (count_q == '0);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and registered result/flags.
// Define ALU_SEQ_DIV_EN to include the iterative divider and the DIV state.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             cout,
    output logic             division_invalid_flag,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    alu_flags_t       flags_q, flags_d;

    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] amt_m1, shr_m1, shl_m1, asr_m1, rot_r;
    logic [SW-1:0]    rot_amt;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] res_r;
    alu_flags_t       res_f;
    logic             use_nz;

    assign sum_w   = {1'b0, x} + {1'b0, y};
    assign diff_w  = {1'b0, x} - {1'b0, y};
    assign add_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum_w[WIDTH-1] != x[WIDTH-1]);
    assign sub_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (diff_w[WIDTH-1] != x[WIDTH-1]);

    // Shifting by amount-1 exposes the last bit shifted out; huge amounts fall out as 0/sign.
    assign amt_m1  = y - WIDTH'(1);
    assign shr_m1  = x >> amt_m1;
    assign shl_m1  = x << amt_m1;
    assign asr_m1  = WIDTH'($signed(x) >>> amt_m1);
    assign rot_amt = y[SW-1:0];
    assign rot_r   = (x >> rot_amt) | (x << (WIDTH - int'(rot_amt)));

    always_comb begin
        res_r  = '0;
        res_f  = '0;
        use_nz = 1'b1;
        case (opcode)
            OP_PASS: res_r = x;
            OP_ADD: begin
                res_r          = sum_w[WIDTH-1:0];
                res_f.cout     = sum_w[WIDTH];
                res_f.overflow = add_ovf;
            end
            OP_SUB: begin
                res_r          = diff_w[WIDTH-1:0];
                res_f.cout     = ~diff_w[WIDTH];
                res_f.overflow = sub_ovf;
            end
            OP_CMPU, OP_CMPS: begin
                use_nz         = 1'b0;
                res_f.cout     = ~diff_w[WIDTH];
                res_f.overflow = sub_ovf;
                res_f.zero     = (diff_w[WIDTH-1:0] == '0);
                res_f.negative = (opcode == OP_CMPS) ? ($signed(x) < $signed(y))
                                                     : diff_w[WIDTH-1];
            end
            OP_AND:  res_r = x & y;
            OP_OR:   res_r = x | y;
            OP_NOR:  res_r = ~(x | y);
            OP_NAND: res_r = ~(x & y);
            OP_XOR:  res_r = x ^ y;
            OP_XNOR: res_r = ~(x ^ y);
            OP_NOT:  res_r = ~x;
            OP_LSR: begin
                res_r      = x >> y;
                res_f.cout = (y != '0) && shr_m1[0];
            end
            OP_LSL: begin
                res_r      = x << y;
                res_f.cout = (y != '0) && shl_m1[WIDTH-1];
            end
            OP_ASR: begin
                res_r      = WIDTH'($signed(x) >>> y);
                res_f.cout = (y != '0) && asr_m1[0];
            end
            OP_ROR: begin
                res_r      = rot_r;
                res_f.cout = (y != '0) && rot_r[WIDTH-1];
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_MOD: begin
                // Only the divide-by-zero case completes here; other cases go through DIV.
                if (y == '0) begin
                    res_r             = (opcode == OP_DIV) ? '1 : x;
                    res_f.div_invalid = 1'b1;
                end
            end
`else
            OP_DIV, OP_MOD: res_f.div_invalid = 1'b1;
`endif
            default: res_r = '0;
        endcase
        if (use_nz) begin
            res_f.negative = res_r[WIDTH-1];
            res_f.zero     = (res_r == '0);
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic             is_mod_q, is_mod_d;
    logic             div_go;
    logic             div_done;
    logic [WIDTH-1:0] div_quot, div_rem;

    assign div_go = (state_q == ST_IDLE) && in_valid && is_divmod(opcode) && (y != '0);

    alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .dividend  (x),
        .divisor   (y),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        flags_d = flags_q;
`ifdef ALU_SEQ_DIV_EN
        is_mod_d = is_mod_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_DIV_EN
                    is_mod_d = (opcode == OP_MOD);
                    if (div_go) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_HOLD;
                        r_d     = res_r;
                        flags_d = res_f;
                    end
`else
                    state_d = ST_HOLD;
                    r_d     = res_r;
                    flags_d = res_f;
`endif
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                if (div_done) begin
                    state_d          = ST_HOLD;
                    r_d              = is_mod_q ? div_rem : div_quot;
                    flags_d          = '0;
                    flags_d.negative = r_d[WIDTH-1];
                    flags_d.zero     = (r_d == '0);
                end
            end
`endif
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            flags_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_mod_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            flags_q <= flags_d;
`ifdef ALU_SEQ_DIV_EN
            is_mod_q <= is_mod_d;
`endif
        end
    end

    assign in_ready              = (state_q == ST_IDLE);
    assign out_valid             = (state_q == ST_HOLD);
    assign busy                  = (state_q != ST_IDLE);
    assign r                     = r_q;
    assign negative              = flags_q.negative;
    assign zero                  = flags_q.zero;
    assign overflow              = flags_q.overflow;
    assign cout                  = flags_q.cout;
    assign division_invalid_flag = flags_q.div_invalid;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16); flags are packed {neg,zero,ovf,cout,dinv}.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [15:0] x, y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        negative, zero, overflow, cout, division_invalid_flag;
    logic        busy;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_errors = 0;

    assign flags = {negative, zero, overflow, cout, division_invalid_flag};

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .opcode                (opcode),
        .x                     (x),
        .y                     (y),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .r                     (r),
        .negative              (negative),
        .zero                  (zero),
        .overflow              (overflow),
        .cout                  (cout),
        .division_invalid_flag (division_invalid_flag),
        .busy                  (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Issue one request, wait for the result, check latency/r/flags, then complete the handshake.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_r,
                          input logic [4:0] exp_f, input int exp_lat);
        int lat;
        check({tag, "_rdy"}, in_ready, 1);
        opcode   = op;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_r"}, r, exp_r);
        check({tag, "_flags"}, flags, exp_f);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_r", r, 0);
        check("rst_flags", flags, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_irdy", in_ready, 1);

        run_op("add_ovf", 5'b00001, 16'h7FFF, 16'h0001, 16'h8000, 5'b10100, 1);
        run_op("add_carry", 5'b00001, 16'hFFFF, 16'h0001, 16'h0000, 5'b01010, 1);
        run_op("sub_eq", 5'b00010, 16'h0005, 16'h0005, 16'h0000, 5'b01010, 1);
        run_op("cmps", 5'b11110, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 1);
        run_op("cmpu", 5'b00101, 16'h0003, 16'h0005, 16'h0000, 5'b10000, 1);
        run_op("xor", 5'b01010, 16'hA5A5, 16'hFFFF, 16'h5A5A, 5'b00000, 1);
        run_op("asr20", 5'b11010, 16'h8000, 16'd20, 16'hFFFF, 5'b10010, 1);
        run_op("ror17", 5'b11100, 16'h0001, 16'd17, 16'h8000, 5'b10010, 1);
        run_op("lsl1", 5'b11001, 16'h8001, 16'd1, 16'h0002, 5'b00010, 1);
        run_op("lsr16", 5'b11000, 16'h00F0, 16'd16, 16'h0000, 5'b01000, 1);
        run_op("unlisted", 5'b10101, 16'h1234, 16'h0003, 16'h0000, 5'b01000, 1);
`ifdef ALU_SEQ_DIV_EN
        run_op("div", 5'b01101, 16'd100, 16'd7, 16'd14, 5'b00000, 17);
        run_op("mod", 5'b01110, 16'd100, 16'd7, 16'd2, 5'b00000, 17);
        run_op("div0", 5'b01101, 16'd100, 16'd0, 16'hFFFF, 5'b10001, 1);
        run_op("mod0", 5'b01110, 16'd100, 16'd0, 16'd100, 5'b00001, 1);
`else
        run_op("div", 5'b01101, 16'd100, 16'd7, 16'd0, 5'b01001, 1);
        run_op("mod", 5'b01110, 16'd100, 16'd7, 16'd0, 5'b01001, 1);
        run_op("div0", 5'b01101, 16'd100, 16'd0, 16'd0, 5'b01001, 1);
`endif

        // Backpressure: result held while a second request waits at the input.
        opcode = 5'b00001; x = 16'd1; y = 16'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        opcode = 5'b00110; x = 16'h00FF; y = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            check("bp_ovalid", out_valid, 1);
            check("bp_irdy", in_ready, 0);
            check("bp_r", r, 16'd2);
            check("bp_flags", flags, 5'b00000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_drop", out_valid, 0);
        check("bp_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp2_ovalid", out_valid, 1);
        check("bp2_r", r, 16'h000F);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset mid-operation discards the pending result.
`ifdef ALU_SEQ_DIV_EN
        opcode = 5'b01101; x = 16'd100; y = 16'd7;
`else
        opcode = 5'b01010; x = 16'h00FF; y = 16'h0F00;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        check("abort_ovalid", out_valid, 0);
        check("abort_r", r, 0);
        check("abort_busy0", busy, 0);
        check("abort_irdy", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort_noresult", seen, 0);
        run_op("add_after", 5'b00001, 16'd2, 16'd3, 16'd5, 5'b00000, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width (legal 4..64, power of two).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  operation request valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have ports opcode  input  5, x  input  WIDTH, y  input  WIDTH: operation code and operands.
REQ-007 The block SHALL have port out_valid  output  1  result/flags valid.
REQ-008 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-009 The block SHALL have ports r  output  WIDTH, and negative, zero, overflow, cout, division_invalid_flag  output  1 each: registered result and flags.
REQ-010 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 Opcodes SHALL be: 00000 pass x; 00001 add; 00010 sub (x-y); 00101 cmp unsigned; 11110 cmp signed; 00110 and; 00111 or; 01000 nor; 01001 nand; 01010 xor; 01011 xnor; 01100 not x; 01101 div; 01110 mod; 11000 LSR; 11001 LSL; 11010 ASR; 11100 ROR.
REQ-012 Unlisted opcodes SHALL complete as single-cycle ops with r=0, zero=1, and all other flags 0.
REQ-013 FSM states SHALL be IDLE, DIV, HOLD; in_ready=1 only in IDLE; a request is accepted on a cycle where in_valid&&in_ready, and opcode/x/y are captured on acceptance.
REQ-014 Single-cycle ops SHALL go IDLE->HOLD with out_valid=1 on the cycle after acceptance.
REQ-015 Div/mod with y!=0 SHALL go IDLE->DIV, run one restoring-division step per cycle for exactly WIDTH cycles, then go to HOLD, giving out_valid WIDTH+1 cycles after acceptance.
REQ-016 Div/mod with y==0 SHALL skip DIV and reach HOLD in one cycle with division_invalid_flag=1, r=all-ones for div, and r=x for mod.
REQ-017 In HOLD, r and all flags SHALL stay stable while out_ready=0; out_valid&&out_ready SHALL return the FSM to IDLE on the next cycle, and out_valid SHALL drop on that cycle.
REQ-018 Division SHALL be unsigned; div returns the quotient and mod the remainder.
REQ-019 For every op, negative=r[WIDTH-1] and zero=(r==0), except for compares.
REQ-020 Add/sub SHALL set overflow=signed overflow; cout=carry-out for add and cout=no-borrow (x>=y unsigned) for sub.
REQ-021 Compares SHALL set r=0 and flags as for sub; signed cmp SHALL set negative=(x<y signed).
REQ-022 Shift amount SHALL be y interpreted as unsigned; for amounts >=WIDTH, LSL/LSR give 0 and ASR gives sign fill; ROR uses the amount mod WIDTH.
REQ-023 Shifts SHALL set cout=last bit shifted out (0 for amount 0); shifts and logic ops SHALL set overflow=0.
REQ-024 division_invalid_flag SHALL be 0 for every op except div/mod by zero.

Reset
REQ-025 A cycle with rst=1 SHALL force state=IDLE, r=0, all flags=0, out_valid=0, and busy=0, and in_ready=1 SHALL follow on the next cycle.
REQ-026 rst asserted during DIV or HOLD SHALL abort the operation and discard the result; no out_valid SHALL be produced for it.
REQ-027 rst SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-028 Macro ALU_SEQ_DIV_EN defined SHALL include the iterative divider and DIV state as specified.
REQ-029 Without ALU_SEQ_DIV_EN, div/mod SHALL complete in one cycle with r=0, zero=1, and division_invalid_flag=1, and state DIV SHALL not exist.

Structure
REQ-030 The shared package alu_pkg SHALL hold the opcode localparams, the FSM state enum, and the flag bundle typedef.
REQ-031 The iterative divider SHALL be the sub-module alu_seq_divider (start, done, quotient, remainder; WIDTH-parameterised).

Verification
REQ-032 WIDTH=16, add 0x7FFF+0x0001 -> r=0x8000, overflow=1, negative=1, cout=0, out_valid 1 cycle after accept.
REQ-033 sub 0x0005-0x0005 -> r=0, zero=1, cout=1; cmp signed x=0xFFFF, y=0x0001 -> r=0, negative=1.
REQ-034 div 100/7 -> r=14 at cycle 17 after accept; mod 100/7 -> r=2; div by 0 -> r=0xFFFF, division_invalid_flag=1 after 1 cycle.
REQ-035 ASR 0x8000 by 20 -> r=0xFFFF; ROR 0x0001 by 17 -> r=0x8000; LSL 0x8001 by 1 -> r=0x0002, cout=1.
REQ-036 out_ready held 0 for 5 cycles -> r/flags stable, in_ready=0; a new in_valid is not accepted until the cycle after the out_valid&&out_ready handshake.
REQ-037 rst pulse at DIV cycle 8 -> next cycle IDLE, out_valid=0, r=0; a following add completes normally.
